// File: rtl/branch_redirect_unit.sv
// -----------------------------------------------------------------------------
// branch_redirect_unit
//
// Purpose:
//   Produces the IF-stage next-PC prediction from a direct-mapped branch target
//   buffer (BTB) and the MSB of the 2-bit branch history counter.
//   Each prediction is carried down the IF -> ID -> EX pipeline. In EX it is
//   compared with the resolved branch. On a mismatch the unit raises flush and
//   supplies the corrected fetch PC. It also keeps saturating counters of
//   resolved branches and mispredicts.
//
// Ports:
//   clk            system clock, all state on the rising edge
//   rst            synchronous reset, active-low
//   stall          pipeline stall: holds tracking slots, suppresses EX updates
//   IF_pc          PC being fetched
//   history_taken  MSB of the 2-bit branch history counter
//   pred_taken     IF prediction: branch taken
//   pred_pc        IF predicted next PC
//   EX_op          opcode in EX (`B_type = conditional branch)
//   EX_pc          PC of the instruction in EX
//   EX_target      computed branch target in EX
//   actual_taken   resolved branch outcome
//   flush          mispredict: squash IF/ID and redirect fetch
//   redirect_pc    corrected fetch PC, zero when flush=0
//   branch_cnt     resolved conditional branch count, saturating
//   mispred_cnt    mispredict count, saturating
// -----------------------------------------------------------------------------
`ifndef B_type
`define B_type 7'b1100011
`endif

module branch_redirect_unit #(
    parameter int BTB_ENTRIES = 16,
    parameter int IDX_W       = $clog2(BTB_ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] IF_pc,
    input  logic        history_taken,
    output logic        pred_taken,
    output logic [31:0] pred_pc,
    input  logic [6:0]  EX_op,
    input  logic [31:0] EX_pc,
    input  logic [31:0] EX_target,
    input  logic        actual_taken,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int TAG_W = 32 - IDX_W - 2;

    // BTB storage. Only the valid bits need a reset; tag and target are
    // meaningless while the entry is invalid.
    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
    logic [31:0]            target_q [BTB_ENTRIES];

    // Tracking slots
    logic        id_v_q,      id_v_d;
    logic        id_taken_q,  id_taken_d;
    logic [31:0] id_target_q, id_target_d;
    logic        ex_v_q,      ex_v_d;
    logic        ex_taken_q,  ex_taken_d;
    logic [31:0] ex_target_q, ex_target_d;

    logic [31:0] branch_cnt_q,  branch_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    // IF lookup
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;
    logic [31:0]      if_btb_target;

    // EX resolution
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_resolve;
    logic             ex_predicted;
    logic             ex_mispredict;
    logic             btb_we;

    // Per-entry write enables for the BTB.
    logic [BTB_ENTRIES-1:0] entry_we;

    assign if_idx = IF_pc[IDX_W+1:2];
    assign if_tag = IF_pc[31:IDX_W+2];
    assign ex_idx = EX_pc[IDX_W+1:2];
    assign ex_tag = EX_pc[31:IDX_W+2];

    // The lookup reads the registered array directly, so a write resolving
    // in EX during the same cycle is only visible from the next cycle on
    // (read-before-write).
    assign if_btb_target = target_q[if_idx];
    assign if_hit        = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken    = if_hit && history_taken;
    assign pred_pc       = pred_taken ? if_btb_target : IF_pc + 32'd4;

    assign ex_resolve    = (EX_op == `B_type) && !stall;
    assign ex_predicted  = ex_v_q && ex_taken_q;
    assign ex_mispredict = (actual_taken != ex_predicted) ||
                           (actual_taken && ex_predicted && (ex_target_q != EX_target));
    assign flush         = ex_resolve && ex_mispredict;
    assign btb_we        = ex_resolve && actual_taken;

    always_comb begin
        redirect_pc = 32'd0;
        if (flush) begin
            redirect_pc = actual_taken ? EX_target : EX_pc + 32'd4;
        end
    end

    generate
        for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : g_entry_we
            assign entry_we[gi] = btb_we && (ex_idx == IDX_W'(gi));
        end
    endgenerate

    // Tracking slot next-state: a flush squashes everything in flight,
    // including the instruction being fetched this cycle.
    always_comb begin
        id_v_d      = id_v_q;
        id_taken_d  = id_taken_q;
        id_target_d = id_target_q;
        ex_v_d      = ex_v_q;
        ex_taken_d  = ex_taken_q;
        ex_target_d = ex_target_q;
        if (flush) begin
            id_v_d = 1'b0;
            ex_v_d = 1'b0;
        end else if (!stall) begin
            id_v_d      = 1'b1;
            id_taken_d  = pred_taken;
            id_target_d = if_btb_target;
            ex_v_d      = id_v_q;
            ex_taken_d  = id_taken_q;
            ex_target_d = id_target_q;
        end
    end

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (ex_resolve && (branch_cnt_q != 32'hFFFF_FFFF)) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
        end
        if (flush && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            id_v_q        <= 1'b0;
            id_taken_q    <= 1'b0;
            id_target_q   <= 32'd0;
            ex_v_q        <= 1'b0;
            ex_taken_q    <= 1'b0;
            ex_target_q   <= 32'd0;
            branch_cnt_q  <= 32'd0;
            mispred_cnt_q <= 32'd0;
        end else begin
            id_v_q        <= id_v_d;
            id_taken_q    <= id_taken_d;
            id_target_q   <= id_target_d;
            ex_v_q        <= ex_v_d;
            ex_taken_q    <= ex_taken_d;
            ex_target_q   <= ex_target_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_q | entry_we;
        end
    end

    // Tag/target array: no reset, written only for taken branches.
    always_ff @(posedge clk) begin
        if (rst && btb_we) begin
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= EX_target;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: doc/branch_redirect_unit.md
Name: branch_redirect_unit

Overview:
- Consumer side of the 2-bit branch history counter. The counter is written in EX; this block reads its prediction bit in IF.
- Combines the history bit with a direct-mapped branch target buffer (BTB) to produce the IF-stage next-PC prediction.
- Carries each prediction down the IF→ID→EX pipeline and compares it with the resolved branch in EX.
- On mismatch, raises flush and supplies the corrected PC. Also keeps branch and mispredict statistics counters.

Parameters:
- BTB_ENTRIES, 16, number of BTB entries; power of two, ≥2.
- IDX_W, $clog2(BTB_ENTRIES), BTB index width. Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2].

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-low (asserted when 0)
- stall  in  1  pipeline stall; holds tracking registers and suppresses EX-side updates
- IF_pc  in  32  PC being fetched
- history_taken  in  1  MSB of the 2-bit branch history counter
- pred_taken  out  1  IF prediction: branch taken
- pred_pc  out  32  IF predicted next PC
- EX_op  in  7  opcode in EX; `B_type marks a conditional branch
- EX_pc  in  32  PC of the instruction in EX
- EX_target  in  32  computed branch target in EX
- actual_taken  in  1  resolved branch outcome from the ALU
- flush  out  1  mispredict: squash IF/ID, redirect fetch
- redirect_pc  out  32  corrected fetch PC, valid when flush=1
- branch_cnt  out  32  resolved B_type count, saturating
- mispred_cnt  out  32  mispredict count, saturating

Behaviour:
- BTB state per entry: valid, tag (32-IDX_W-2 bits), target (32 bits).
- Reset (rst=0 at an edge):
  - all BTB valid bits cleared;
  - tracking registers cleared;
  - both counters set to 0.
- Reset mid-operation discards all in-flight predictions. Outputs after reset: pred_taken=0, pred_pc=IF_pc+4, flush=0, redirect_pc=0.
- IF lookup, combinational, zero latency:
  - hit = valid[idx] && tag[idx]==IF_pc tag.
  - pred_taken = hit && history_taken.
  - pred_pc = pred_taken ? target[idx] : IF_pc+4. All PC arithmetic is 32-bit modulo 2^32.
- Tracking pipeline, registered:
  - ID_slot {v, taken, target} is captured from IF at an edge when stall=0.
  - EX_slot is captured from ID_slot at an edge when stall=0.
  - When stall=1, both slots hold.
- EX resolution, combinational; active only when EX_op==`B_type and stall=0:
  - predicted = EX_slot.v && EX_slot.taken.
  - mispredict = (actual_taken != predicted) || (actual_taken && predicted && EX_slot.target != EX_target).
  - flush = mispredict.
  - redirect_pc = actual_taken ? EX_target : EX_pc+4.
  - When flush=0, redirect_pc = 0.
- Flush effect at the edge: ID_slot and EX_slot are cleared (v=0). This takes priority over normal capture; the instruction fetched that cycle is not captured.
- Stall: when stall=1, flush is forced to 0 and there are no BTB or counter updates. Resolution happens in the first non-stalled cycle.
- BTB update at the edge, when EX_op==`B_type, stall=0 and actual_taken=1: write entry idx(EX_pc) with valid=1, tag(EX_pc), target=EX_target.
  - Not-taken branches never write or invalidate entries.
- Same-cycle read/write to the same index: the IF lookup sees the pre-write contents (read-before-write).
- Counters: on each resolved B_type, branch_cnt increments; mispred_cnt increments when flush=1. Both saturate at 32'hFFFF_FFFF.
- Non-B_type in EX: flush=0, no updates. The EX slot simply retires.

Test Plan:
1. Reset, then cold lookup.
   - Stimulus: rst=0 for 2 cycles, release; IF_pc=0x100, history_taken=1.
   - Required: pred_taken=0, pred_pc=0x104; counters both 0.
2. First taken branch trains the BTB.
   - Stimulus: branch at 0x100 flows to EX with actual_taken=1, EX_target=0x200.
   - Required: flush=1, redirect_pc=0x200, branch_cnt=1, mispred_cnt=1.
   - Follow-up: the next IF at 0x100 with history_taken=1 gives pred_taken=1, pred_pc=0x200.
3. Correctly predicted taken branch.
   - Stimulus: same branch again, actual_taken=1, EX_target=0x200.
   - Required: flush=0, branch_cnt=2, mispred_cnt unchanged.
4. Predicted taken, actually not taken.
   - Stimulus: EX_pc=0x100, actual_taken=0.
   - Required: flush=1, redirect_pc=0x104; ID/EX slots cleared next cycle; BTB entry still valid.
5. Stall during resolution.
   - Stimulus: mispredicting branch in EX with stall=1 for 3 cycles, then stall=0.
   - Required: flush=0 and counters frozen while stalled; a single flush pulse on the first cycle with stall=0.
6. Alias and same-cycle access (BTB_ENTRIES=16).
   - Stimulus: taken branch 0x140 (target 0x300) resolves while IF_pc=0x40 (same index).
   - Required: that cycle IF uses old entry contents; next cycle IF_pc=0x40 misses on tag, giving pred_pc=0x44.
